// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter
// Shares the register-file write port between the writeback stage (priority) and
// a small FIFO of multi-cycle unit results. A starvation guard forces one FIFO
// grant (stalling WB) after STARVE_MAX cycles of a waiting, ungranted FIFO head.
// Optional build macro: R0_DISCARD_EN -- writes to register 0 are dropped
// (WB grant to r0 gives no rf_we; MC results for r0 are handshaken but not queued).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_NORMAL | WB has priority; FIFO head granted when WB is idle
// ST_FORCE  | WB stalled for one cycle; FIFO head granted unconditionally

module regfile_wport_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_we,
    input  logic [ADDR_W-1:0]    wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 mc_valid,
    output logic                 mc_ready,
    input  logic [ADDR_W-1:0]    mc_rd,
    input  logic [DATA_W-1:0]    mc_data,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 stall_wb,
    output logic [2**ADDR_W-1:0] pending_mask
);

    localparam int NREG  = 2**ADDR_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                grant_wb, grant_fifo;
    logic                wb_write, push, enq;
    logic                fifo_full, fifo_empty;

    logic [ADDR_W-1:0]   fifo_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_vld;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign fifo_full  = &slot_vld;
    assign fifo_empty = ~|slot_vld;
    // A pop in the same cycle never frees a slot early: ready looks only at current occupancy.
    assign mc_ready   = rst_n & ~fifo_full;
    assign push       = mc_valid & mc_ready;
    assign stall_wb   = (state == ST_FORCE);

`ifdef R0_DISCARD_EN
    assign enq      = push & (mc_rd != '0);
    assign wb_write = grant_wb & (wb_rd != '0);
`else
    assign enq      = push;
    assign wb_write = grant_wb;
`endif

    // Arbitration, starvation counting and next-state selection.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        grant_wb   = 1'b0;
        grant_fifo = 1'b0;
        case (state)
            ST_NORMAL: begin
                if (wb_we)
                    grant_wb = 1'b1;
                else if (!fifo_empty)
                    grant_fifo = 1'b1;
                if (fifo_empty || grant_fifo)
                    cnt_next = '0;
                else
                    cnt_next = cnt + 1'b1;
                if (cnt_next == CNT_W'(STARVE_MAX))
                    state_next = ST_FORCE;
            end
            ST_FORCE: begin
                grant_fifo = !fifo_empty;
                cnt_next   = '0;
                state_next = ST_NORMAL;
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_NORMAL;
            end
        endcase
    end

    // State register and starvation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_NORMAL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // FIFO occupancy and ring pointers; a pushed entry is only visible next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_vld <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (enq) begin
                slot_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (grant_fifo) begin
                slot_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= ptr_inc(rd_ptr);
            end
        end
    end

    // FIFO payload storage; contents are qualified by slot_vld so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wr_ptr]   <= mc_rd;
            fifo_data[wr_ptr] <= mc_data;
        end
    end

    // Registered write port; address and data hold when nothing is written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= wb_write | grant_fifo;
            if (wb_write) begin
                rf_waddr <= wb_rd;
                rf_wdata <= wb_data;
            end else if (grant_fifo) begin
                rf_waddr <= fifo_rd[rd_ptr];
                rf_wdata <= fifo_data[rd_ptr];
            end
        end
    end

    // Pending-register mask: one bit per destination held in the FIFO.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_vld[i])
                pending_mask[fifo_rd[i]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter (default parameters).
module tb_regfile_wport_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wb_we;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       mc_valid;
    logic       mc_ready;
    logic [2:0] mc_rd;
    logic [7:0] mc_data;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       stall_wb;
    logic [7:0] pending_mask;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_wport_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .mc_valid     (mc_valid),
        .mc_ready     (mc_ready),
        .mc_rd        (mc_rd),
        .mc_data      (mc_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .stall_wb     (stall_wb),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       wb_we;
        logic [2:0] wb_rd;
        logic [7:0] wb_data;
        logic       mc_valid;
        logic [2:0] mc_rd;
        logic [7:0] mc_data;
        logic       e_we;
        logic [2:0] e_addr;
        logic [7:0] e_data;
        logic       e_ready;
        logic       e_stall;
        logic [7:0] e_mask;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic we, input logic [2:0] rd, input logic [7:0] d,
        input logic mv, input logic [2:0] mrd, input logic [7:0] md,
        input logic ewe, input logic [2:0] ea, input logic [7:0] ed,
        input logic erdy, input logic est, input logic [7:0] em);
        vec_t v;
        v.rst_n = r;   v.wb_we = we;  v.wb_rd = rd; v.wb_data = d;
        v.mc_valid = mv; v.mc_rd = mrd; v.mc_data = md;
        v.e_we = ewe;  v.e_addr = ea; v.e_data = ed;
        v.e_ready = erdy; v.e_stall = est; v.e_mask = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic we, input logic [2:0] rd, input logic [7:0] d,
                         input logic mv, input logic [2:0] mrd, input logic [7:0] md);
        rst_n = r; wb_we = we; wb_rd = rd; wb_data = d;
        mc_valid = mv; mc_rd = mrd; mc_data = md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ewe, input logic [2:0] ea,
                           input logic [7:0] ed, input logic erdy, input logic est,
                           input logic [7:0] em);
        chk({tag, " rf_we"},        32'(rf_we),        32'(ewe));
        chk({tag, " rf_waddr"},     32'(rf_waddr),     32'(ea));
        chk({tag, " rf_wdata"},     32'(rf_wdata),     32'(ed));
        chk({tag, " mc_ready"},     32'(mc_ready),     32'(erdy));
        chk({tag, " stall_wb"},     32'(stall_wb),     32'(est));
        chk({tag, " pending_mask"}, 32'(pending_mask), 32'(em));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;

        // Each row: apply inputs for one cycle, then check outputs just after the edge.
        //            rst we rd  data   mv rd  data    we ad  data   rdy st mask
        // reset held 3 cycles with both requesters active
        vecs.push_back(mk(0, 1, 3, 8'hAA, 1, 5, 8'h11,  0, 0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 3, 8'hAA, 1, 5, 8'h11,  0, 0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 3, 8'hAA, 1, 5, 8'h11,  0, 0, 8'h00, 0, 0, 8'h00));
        // first cycle after release: push r5, pending next cycle
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 5, 8'h11,  0, 0, 8'h00, 1, 0, 8'h20));
        // idle WB: FIFO head written one cycle later
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00,  1, 5, 8'h11, 1, 0, 8'h00));
        // WB only
        vecs.push_back(mk(1, 1, 3, 8'h5A, 0, 0, 8'h00,  1, 3, 8'h5A, 1, 0, 8'h00));
        // no grant: address/data hold
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00,  0, 3, 8'h5A, 1, 0, 8'h00));
`ifdef R0_DISCARD_EN
        vecs.push_back(mk(1, 1, 0, 8'h77, 0, 0, 8'h00,  0, 3, 8'h5A, 1, 0, 8'h00));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h33,  0, 3, 8'h5A, 1, 0, 8'h00));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00,  0, 3, 8'h5A, 1, 0, 8'h00));
`else
        vecs.push_back(mk(1, 1, 0, 8'h77, 0, 0, 8'h00,  1, 0, 8'h77, 1, 0, 8'h00));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h33,  0, 0, 8'h77, 1, 0, 8'h01));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00,  1, 0, 8'h33, 1, 0, 8'h00));
`endif
        // starvation: r6 queued while WB writes every cycle
        vecs.push_back(mk(1, 1, 1, 8'hA0, 1, 6, 8'h66,  1, 1, 8'hA0, 1, 0, 8'h40));
        vecs.push_back(mk(1, 1, 2, 8'hA1, 0, 0, 8'h00,  1, 2, 8'hA1, 1, 0, 8'h40));
        vecs.push_back(mk(1, 1, 3, 8'hA2, 0, 0, 8'h00,  1, 3, 8'hA2, 1, 0, 8'h40));
        vecs.push_back(mk(1, 1, 4, 8'hA3, 0, 0, 8'h00,  1, 4, 8'hA3, 1, 0, 8'h40));
        vecs.push_back(mk(1, 1, 5, 8'hA4, 0, 0, 8'h00,  1, 5, 8'hA4, 1, 1, 8'h40));
        // FORCE cycle: WB ignored, queued r6 written
        vecs.push_back(mk(1, 1, 7, 8'hA5, 0, 0, 8'h00,  1, 6, 8'h66, 1, 0, 8'h00));
        // held WB instruction re-presented and written
        vecs.push_back(mk(1, 1, 7, 8'hA5, 0, 0, 8'h00,  1, 7, 8'hA5, 1, 0, 8'h00));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00,  0, 7, 8'hA5, 1, 0, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_data,
                  vecs[i].mc_valid, vecs[i].mc_rd, vecs[i].mc_data);
            tick();
            chk_out($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data,
                    vecs[i].e_ready, vecs[i].e_stall, vecs[i].e_mask);
        end

        // Full FIFO: WB busy while two entries are pushed; third is held off.
        drive(1, 1, 1, 8'hB0, 1, 2, 8'hC2);
        tick();
        chk_out("full0", 1, 1, 8'hB0, 1, 0, 8'h04);
        drive(1, 1, 1, 8'hB1, 1, 3, 8'hC3);
        tick();
        chk_out("full1", 1, 1, 8'hB1, 0, 0, 8'h0C);
        drive(1, 1, 1, 8'hB2, 1, 4, 8'hC4);
        tick();
        chk_out("full2", 1, 1, 8'hB2, 0, 0, 8'h0C);
        // first pop; ready must not rise in the pop cycle itself
        drive(1, 0, 0, 8'h00, 1, 4, 8'hC4);
        tick();
        chk_out("pop1", 1, 2, 8'hC2, 1, 0, 8'h08);
        // third entry accepted now, second entry written
        tick();
        chk_out("pop2", 1, 3, 8'hC3, 1, 0, 8'h10);
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00);
        // bounded wait for the held entry to reach the write port
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (k != 0) tick();
            else tick();
            if (rf_we && rf_waddr == 3'd4) got = 1'b1;
        end
        chk("drain seen", 32'(got), 32'd1);
        chk("drain data", 32'(rf_wdata), 32'hC4);
        chk("drain mask", 32'(pending_mask), 32'h00);

        // Reset mid-traffic clears the FIFO and the write port.
        drive(1, 1, 1, 8'hD0, 1, 2, 8'hE2);
        tick();
        drive(1, 1, 1, 8'hD1, 1, 3, 8'hE3);
        tick();
        chk("pre-reset mask", 32'(pending_mask), 32'h0C);
        drive(0, 1, 1, 8'hD2, 1, 4, 8'hE4);
        tick();
        chk_out("rst", 0, 0, 8'h00, 0, 0, 8'h00);
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        chk_out("post-rst", 0, 0, 8'h00, 1, 0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
